sobel_frame_writer: RTL and testbench

- Sink end of the Sobel pixel stream: takes the filtered result stream from the Sobel datapath (one result per cycle while `done_i` is high) and writes a full ROWS x COLS output frame into frame RAM.
- Interior results fill addresses in raster order; the 1-pixel border, which the 3x3 window cannot produce, is written as 0.
- A small internal FIFO absorbs the stalls caused by inserting border writes between interior runs.

---
 rtl/sobel_pkg.sv | 27 ++
 rtl/sobel_sync_fifo.sv | 82 ++++++++
 rtl/sobel_frame_writer.sv | 169 ++++++++++++++++
 tb/tb_sobel_frame_writer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Shared definitions for the Sobel pipeline blocks.
//   - wr_state_t : frame-writer FSM state encoding (IDLE, WRITE, DONE)
//   - PIX_MAX    : largest value representable in an 8-bit output pixel
//   - DEF_ROWS / DEF_COLS : default frame geometry, shared with the
//                           line-buffer block so both ends agree on size
//   - interior_count() : number of pixels the 3x3 window can produce
// -----------------------------------------------------------------------------
package sobel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } wr_state_t;

   localparam int PIX_MAX  = 255;
   localparam int DEF_ROWS = 5;
   localparam int DEF_COLS = 6;

   // Pixels that are not on the 1-pixel border of a rows x cols frame.
   function automatic int interior_count(input int rows, input int cols);
      return (rows - 2) * (cols - 2);
   endfunction

endpackage

// File: rtl/sobel_sync_fifo.sv
// -----------------------------------------------------------------------------
// sobel_sync_fifo
// Single-clock FIFO with a register-array memory and read/write pointers.
// dout always shows the entry at the head, so a pop consumes the value that
// is visible in the same cycle.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-low reset (empties the FIFO)
//   clr   in   synchronous flush, returns the FIFO to empty
//   push  in   write din (ignored while full)
//   pop   in   consume head entry (ignored while empty)
//   din   in   WIDTH write data
//   dout  out  WIDTH head entry
//   full  out  DEPTH entries stored
//   empty out  no entries stored
// -----------------------------------------------------------------------------
module sobel_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW:0]      r_count;

   logic w_do_push;
   logic w_do_pop;

   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   assign full  = (r_count == (PW+1)'(DEPTH));
   assign empty = (r_count == '0);
   assign dout  = r_mem[r_rd_ptr];

   // Storage carries no reset so it can map onto distributed RAM.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/sobel_frame_writer.sv
// -----------------------------------------------------------------------------
// sobel_frame_writer
// Sink of the Sobel result stream. Interior results are buffered in a small
// FIFO and written to frame RAM in raster order; border pixels, which the
// 3x3 window cannot produce, are written as 0 in between.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   done_i       in   result-valid strobe, pixel_i sampled when high
//   pixel_i      in   MW unsigned gradient magnitude
//   mem_we_o     out  frame RAM write enable
//   mem_addr_o   out  AW frame RAM write address (row*COLS+col)
//   mem_data_o   out  8-bit saturated write data
//   busy_o       out  high from frame start until frame_done_o
//   frame_done_o out  one-cycle pulse after the last write of a frame
//   overflow_o   out  sticky: a pixel was dropped (cleared only by reset)
// -----------------------------------------------------------------------------
module sobel_frame_writer
   import sobel_pkg::*;
#(
   parameter int ROWS  = DEF_ROWS,
   parameter int COLS  = DEF_COLS,
   parameter int MW    = 11,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(ROWS*COLS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          done_i,
   input  logic [MW-1:0] pixel_i,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [7:0]    mem_data_o,
   output logic          busy_o,
   output logic          frame_done_o,
   output logic          overflow_o
);

   localparam int RW   = $clog2(ROWS);
   localparam int CW   = $clog2(COLS);
   localparam int NINT = interior_count(ROWS, COLS);
   localparam int NW   = $clog2(NINT + 1);

   localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
   localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(ROWS*COLS - 1);
   localparam logic [NW-1:0] NINT_C    = NW'(NINT);

   wr_state_t     r_state;
   logic [RW-1:0] r_row;
   logic [CW-1:0] r_col;
   logic [AW-1:0] r_addr;
   logic [NW-1:0] r_acc_cnt;

   logic       w_border;
   logic       w_full;
   logic       w_empty;
   logic [7:0] w_fifo_dout;
   logic [7:0] w_sat;
   logic       w_active;
   logic       w_accept_ok;
   logic       w_push;
   logic       w_drop_err;
   logic       w_pop;
   logic       w_clr;

   assign w_border = (r_row == '0) || (r_row == LAST_ROW) ||
                     (r_col == '0) || (r_col == LAST_COL);

   // Saturate before buffering so the FIFO only has to hold 8 bits.
   assign w_sat = (pixel_i > MW'(PIX_MAX)) ? 8'(PIX_MAX) : pixel_i[7:0];

   // Input is only taken while a frame can still absorb it; in DONE the
   // frame is complete and stray pixels are silently discarded.
   assign w_active    = (r_state != ST_DONE);
   assign w_accept_ok = !w_full && (r_acc_cnt < NINT_C);
   assign w_push      = done_i && w_active && w_accept_ok;
   assign w_drop_err  = done_i && w_active && !w_accept_ok;

   assign w_pop = (r_state == ST_WRITE) && !w_border && !w_empty;
   assign w_clr = (r_state == ST_DONE);

   sobel_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_clr),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_sat),
      .dout  (w_fifo_dout),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_row        <= '0;
         r_col        <= '0;
         r_addr       <= '0;
         r_acc_cnt    <= '0;
         mem_we_o     <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
         busy_o       <= 1'b0;
         frame_done_o <= 1'b0;
         overflow_o   <= 1'b0;
      end else begin
         mem_we_o     <= 1'b0;
         frame_done_o <= 1'b0;

         if (w_push) begin
            r_acc_cnt <= r_acc_cnt + 1'b1;
         end
         if (w_drop_err) begin
            overflow_o <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               // The starting pixel itself is pushed by w_push above.
               if (done_i) begin
                  r_state <= ST_WRITE;
                  busy_o  <= 1'b1;
               end
            end

            ST_WRITE: begin
               // Interior position with nothing buffered: stall, holding
               // position and the last presented address.
               if (w_border || !w_empty) begin
                  mem_we_o   <= 1'b1;
                  mem_addr_o <= r_addr;
                  mem_data_o <= w_border ? 8'd0 : w_fifo_dout;
                  r_addr     <= r_addr + 1'b1;
                  if (r_col == LAST_COL) begin
                     r_col <= '0;
                     r_row <= r_row + 1'b1;
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
                  if (r_addr == LAST_ADDR) begin
                     r_state <= ST_DONE;
                  end
               end
            end

            ST_DONE: begin
               frame_done_o <= 1'b1;
               busy_o       <= 1'b0;
               r_row        <= '0;
               r_col        <= '0;
               r_addr       <= '0;
               r_acc_cnt    <= '0;
               r_state      <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sobel_frame_writer.sv
// -----------------------------------------------------------------------------
// tb_sobel_frame_writer
// Scoreboard bench: each frame's stimulus pushes the full list of expected
// RAM writes (derived from the frame geometry and the pixel list) into a
// queue; an independent monitor pops and compares on every mem_we_o.
// -----------------------------------------------------------------------------
module tb_sobel_frame_writer;

   localparam int ROWS  = 5;
   localparam int COLS  = 6;
   localparam int MW    = 11;
   localparam int DEPTH = 16;
   localparam int AW    = $clog2(ROWS*COLS);
   localparam int NPIX  = ROWS*COLS;
   localparam int NINT  = (ROWS-2)*(COLS-2);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          done_i = 1'b0;
   logic [MW-1:0] pixel_i = '0;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [7:0]    mem_data_o;
   logic          busy_o;
   logic          frame_done_o;
   logic          overflow_o;

   sobel_frame_writer #(
      .ROWS (ROWS), .COLS (COLS), .MW (MW), .DEPTH (DEPTH), .AW (AW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .done_i       (done_i),
      .pixel_i      (pixel_i),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .busy_o       (busy_o),
      .frame_done_o (frame_done_o),
      .overflow_o   (overflow_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   done_cnt = 0;
   int   stall_cnt = 0;
   bit   mon_ignore = 1'b0;
   bit   exp_ovf = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   // Reference: every address in raster order; border is 0, interior
   // positions take the accepted pixels in arrival order.
   task automatic build_expect(input int vals[$]);
      exp_t e;
      for (int p = 0; p < NPIX; p++) begin
         int r;
         int c;
         r = p / COLS;
         c = p % COLS;
         e.addr = p;
         if (r == 0 || r == ROWS-1 || c == 0 || c == COLS-1) begin
            e.data = 0;
         end else begin
            e.data = sat(vals[(r-1)*(COLS-2) + (c-1)]);
         end
         exp_q.push_back(e);
      end
      if (vals.size() > NINT) exp_ovf = 1'b1;
   endtask

   // gap < 0 selects a random 0..3 idle cycles after each pixel.
   task automatic drive(input int vals[$], input int gap);
      foreach (vals[i]) begin
         int g;
         done_i  = 1'b1;
         pixel_i = MW'(vals[i]);
         @(posedge clk); #1;
         done_i = 1'b0;
         g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
         repeat (g) begin
            @(posedge clk); #1;
         end
      end
   endtask

   // stall_mode: 0 = no stalls allowed, 1 = stalls required, else unchecked.
   task automatic run_frame(input string name, input int vals[$],
                            input int gap, input int stall_mode);
      int start;
      int t;
      start = done_cnt;
      stall_cnt = 0;
      build_expect(vals);
      drive(vals, gap);
      t = 0;
      while (done_cnt == start && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
      chk({name, "_frame_done_seen"}, (done_cnt > start) ? 1 : 0, 1);
      chk({name, "_writes_left"}, exp_q.size(), 0);
      chk({name, "_overflow"}, int'(overflow_o), int'(exp_ovf));
      chk({name, "_busy_low"}, int'(busy_o), 0);
      if (stall_mode == 0) chk({name, "_stall_cycles"}, stall_cnt, 0);
      if (stall_mode == 1) chk({name, "_has_stalls"}, (stall_cnt > 0) ? 1 : 0, 1);
      exp_q.delete();
   endtask

   // Monitor: compares every write against the scoreboard.
   int prev_we   = 0;
   int prev_busy = 0;
   int prev_addr = 0;
   int prev_done = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_we = 0; prev_busy = 0; prev_addr = 0; prev_done = 0;
         end else begin
            if (!mon_ignore) begin
               if (mem_we_o) begin
                  if (exp_q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL unexpected_write actual_addr=%0d actual_data=%0d required=no_write",
                              mem_addr_o, mem_data_o);
                  end else begin
                     exp_t e;
                     e = exp_q.pop_front();
                     $display("WR addr=%0d data=%0d exp_addr=%0d exp_data=%0d",
                              mem_addr_o, mem_data_o, e.addr, e.data);
                     chk("wr_addr", int'(mem_addr_o), e.addr);
                     chk("wr_data", int'(mem_data_o), e.data);
                  end
               end else if (busy_o && prev_busy != 0) begin
                  stall_cnt++;
                  chk("stall_addr_hold", int'(mem_addr_o), prev_addr);
               end
               if (frame_done_o) begin
                  done_cnt++;
                  $display("FRAME_DONE count=%0d overflow=%0d", done_cnt, overflow_o);
                  chk("done_after_last_write",
                      (prev_we != 0 && prev_addr == NPIX-1) ? 1 : 0, 1);
                  chk("done_pulse_width", prev_done, 0);
               end
            end
            prev_we   = int'(mem_we_o);
            prev_busy = int'(busy_o);
            prev_addr = int'(mem_addr_o);
            prev_done = int'(frame_done_o);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int vals[$];
      int nw;

      // Reset held with activity on the input.
      for (int i = 0; i < 3; i++) begin
         done_i  = (i % 2 == 0);
         pixel_i = MW'($urandom_range(0, 2047));
         @(posedge clk); #1;
         chk("reset_outputs",
             int'({mem_we_o, mem_addr_o, mem_data_o, busy_o, frame_done_o, overflow_o}), 0);
      end
      done_i = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;

      // Nominal frame.
      vals.delete();
      for (int i = 1; i <= NINT; i++) vals.push_back(i);
      run_frame("nominal", vals, 0, 0);

      // Saturation boundaries.
      vals = '{255, 256, 300, 2047, 0};
      while (vals.size() < NINT) vals.push_back(int'($urandom_range(0, 2047)));
      run_frame("saturation", vals, 0, 0);

      // Gapped input: one pixel every third cycle.
      vals.delete();
      for (int i = 1; i <= NINT; i++) vals.push_back(i);
      run_frame("gapped", vals, 2, 1);

      // Random values with random gaps.
      for (int f = 0; f < 3; f++) begin
         vals.delete();
         for (int i = 0; i < NINT; i++) vals.push_back(int'($urandom_range(0, 2047)));
         run_frame("random", vals, -1, 2);
      end

      // Excess input: last two pixels dropped, overflow sticks.
      vals.delete();
      for (int i = 1; i <= NINT + 2; i++) vals.push_back(i);
      run_frame("excess", vals, 0, 0);

      vals.delete();
      for (int i = 0; i < NINT; i++) vals.push_back(int'($urandom_range(0, 2047)));
      run_frame("after_excess", vals, 0, 0);

      // Reset in the middle of a frame, after the 10th write.
      mon_ignore = 1'b1;
      nw = 0;
      for (int i = 0; i < NINT; i++) begin
         if (nw < 10) begin
            done_i  = 1'b1;
            pixel_i = MW'(i + 100);
            @(posedge clk); #1;
            done_i = 1'b0;
            if (mem_we_o) nw++;
         end
      end
      chk("midreset_ten_writes", (nw >= 10) ? 1 : 0, 1);
      rst = 1'b0;
      #1;
      chk("midreset_outputs",
          int'({mem_we_o, mem_addr_o, mem_data_o, busy_o, frame_done_o, overflow_o}), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      exp_ovf = 1'b0;
      mon_ignore = 1'b0;
      @(posedge clk); #1;

      vals.delete();
      for (int i = 1; i <= NINT; i++) vals.push_back(i);
      run_frame("after_reset", vals, 0, 0);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
